// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared OTTER pipeline types. This file holds the branch-predictor entry
// format and the 2-bit direction counter encodings.
//   bpCtr_t   : 2-bit saturating direction counter encoding
//   bpEntry_t : one predictor table entry (valid, tag, word target, counter)
// -----------------------------------------------------------------------------
package otter_pkg;

    // The tag field is sized for the widest legal tag. The predictor compares
    // and stores only its TAG_BITS low bits, and the unused upper bits are
    // optimised away.
    localparam int BP_TAG_W = 30;
    localparam int BP_TGT_W = 30;   // target[31:2]; targets are word aligned

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,   // strong not-taken
        CTR_WNT = 2'b01,   // weak not-taken
        CTR_WT  = 2'b10,   // weak taken
        CTR_ST  = 2'b11    // strong taken
    } bpCtr_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_TGT_W-1:0] target;
        bpCtr_t              ctr;
    } bpEntry_t;

endpackage

// File: rtl/sat_ctr2.sv
// -----------------------------------------------------------------------------
// sat_ctr2
// Computes the next state of a 2-bit saturating direction counter.
//   ctr          : current counter
//   taken        : resolved outcome (increment when 1, decrement when 0)
//   force_strong : unconditional jump, so the counter goes to strong-taken
//   ctr_next     : next counter value, saturating at 00 and 11
// -----------------------------------------------------------------------------
module sat_ctr2
    import otter_pkg::*;
(
    input  bpCtr_t ctr,
    input  logic   taken,
    input  logic   force_strong,
    output bpCtr_t ctr_next
);

    // NOTE: the default is assigned first so that every path through the
    // block drives ctr_next. This keeps the logic purely combinational and
    // prevents a latch from being inferred.
    always_comb begin
        ctr_next = ctr;
        if (force_strong) begin
            ctr_next = CTR_ST;
        end else if (taken) begin
            if (ctr != CTR_ST) ctr_next = bpCtr_t'(ctr + 2'd1);
        end else begin
            if (ctr != CTR_SNT) ctr_next = bpCtr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/otter_bpred.sv
// -----------------------------------------------------------------------------
// otter_bpred
// Direct-mapped branch target buffer with 2-bit direction counters for the
// OTTER fetch stage. It also keeps resolved-branch and mispredict statistics.
//   CLK, RST                 : clock and synchronous active-high reset
//   PRED_PC                  : fetch PC; lookup is combinational
//   PRED_HIT/TAKEN/TARGET    : lookup result and next fetch PC
//   UPD_*                    : resolved branch/jump from execute, together
//                              with the prediction it carried down the pipe
//   UPD_MISPRED              : combinational flush request
//   STAT_UPD, STAT_MISPRED   : saturating resolved / mispredict counts
// -----------------------------------------------------------------------------
module otter_bpred
    import otter_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         PRED_PC,
    output logic                PRED_HIT,
    output logic                PRED_TAKEN,
    output logic [31:0]         PRED_TARGET,
    input  logic                UPD_EN,
    input  logic [31:0]         UPD_PC,
    input  logic                UPD_TAKEN,
    input  logic [31:0]         UPD_TARGET,
    input  logic                UPD_IS_JUMP,
    input  logic                UPD_PRED_TAKEN,
    input  logic [31:0]         UPD_PRED_TARGET,
    output logic                UPD_MISPRED,
    output logic [CNT_BITS-1:0] STAT_UPD,
    output logic [CNT_BITS-1:0] STAT_MISPRED
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    // Flops rather than a RAM, so that every valid bit can clear in one cycle.
    bpEntry_t bpTable [ENTRIES];

    logic [IDX_BITS-1:0] predIdx, updIdx;
    logic [TAG_BITS-1:0] predTag, updTag;
    bpEntry_t            predEntry, updEntry;
    logic                updHit;
    bpCtr_t              updCtrNext;

    assign predIdx = PRED_PC[IDX_BITS+1:2];
    assign predTag = PRED_PC[IDX_BITS+2 +: TAG_BITS];
    assign updIdx  = UPD_PC[IDX_BITS+1:2];
    assign updTag  = UPD_PC[IDX_BITS+2 +: TAG_BITS];

    // The lookup reads the table as it stands. There is no bypass from a
    // same-cycle update, so a write becomes visible on the following cycle.
    assign predEntry   = bpTable[predIdx];
    assign PRED_HIT    = predEntry.valid && (predEntry.tag == BP_TAG_W'(predTag));
    assign PRED_TAKEN  = PRED_HIT && predEntry.ctr[1];
    assign PRED_TARGET = PRED_TAKEN ? {predEntry.target, 2'b00} : PRED_PC + 32'd4;

    assign updEntry = bpTable[updIdx];
    assign updHit   = updEntry.valid && (updEntry.tag == BP_TAG_W'(updTag));

    assign UPD_MISPRED = UPD_EN && ((UPD_TAKEN != UPD_PRED_TAKEN) ||
                                    (UPD_TAKEN && (UPD_TARGET != UPD_PRED_TARGET)));

    sat_ctr2 u_sat_ctr2 (
        .ctr          (updEntry.ctr),
        .taken        (UPD_TAKEN),
        .force_strong (UPD_IS_JUMP),
        .ctr_next     (updCtrNext)
    );

    // NOTE: reset clears only the valid bits and the counters. Tag and target
    // contents are meaningless while valid=0, so they get no reset and keep
    // plain data flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bpTable[i].valid <= 1'b0;
                bpTable[i].ctr   <= CTR_WNT;
            end
        end else if (UPD_EN) begin
            if (updHit) begin
                bpTable[updIdx].ctr <= updCtrNext;
                if (UPD_TAKEN) bpTable[updIdx].target <= UPD_TARGET[31:2];
            end else if (UPD_TAKEN) begin
                // Direct-mapped: allocation replaces whatever lived here.
                bpTable[updIdx] <= '{valid:  1'b1,
                                     tag:    BP_TAG_W'(updTag),
                                     target: UPD_TARGET[31:2],
                                     ctr:    UPD_IS_JUMP ? CTR_ST : CTR_WT};
            end
        end
    end

    // NOTE: state flops use non-blocking assignments, so every always_ff block
    // reads pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            STAT_UPD     <= '0;
            STAT_MISPRED <= '0;
        end else begin
            if (UPD_EN && (STAT_UPD != '1))
                STAT_UPD <= STAT_UPD + CNT_BITS'(1);
            if (UPD_MISPRED && (STAT_MISPRED != '1))
                STAT_MISPRED <= STAT_MISPRED + CNT_BITS'(1);
        end
    end

    // Low PC bits, tag-less upper PC bits and target byte offset are
    // architecturally irrelevant here.
    logic unusedBits;
    assign unusedBits = ^{PRED_PC, UPD_PC, UPD_TARGET[1:0]};

endmodule

// File: tb/tb_otter_bpred.sv
// -----------------------------------------------------------------------------
// tb_otter_bpred
// Scoreboarded bench for otter_bpred. The stimulus process computes the
// expected outputs from a behavioural table model and queues them. A monitor
// samples the DUT on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_otter_bpred;

    localparam int ENTRIES  = 16;
    localparam int TAG_BITS = 8;
    localparam int CNT_BITS = 16;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_BITS) - 1;

    logic                CLK = 1'b0;
    logic                RST;
    logic [31:0]         PRED_PC;
    logic                PRED_HIT, PRED_TAKEN;
    logic [31:0]         PRED_TARGET;
    logic                UPD_EN, UPD_TAKEN, UPD_IS_JUMP, UPD_PRED_TAKEN;
    logic [31:0]         UPD_PC, UPD_TARGET, UPD_PRED_TARGET;
    logic                UPD_MISPRED;
    logic [CNT_BITS-1:0] STAT_UPD, STAT_MISPRED;

    otter_bpred #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .PRED_PC         (PRED_PC),
        .PRED_HIT        (PRED_HIT),
        .PRED_TAKEN      (PRED_TAKEN),
        .PRED_TARGET     (PRED_TARGET),
        .UPD_EN          (UPD_EN),
        .UPD_PC          (UPD_PC),
        .UPD_TAKEN       (UPD_TAKEN),
        .UPD_TARGET      (UPD_TARGET),
        .UPD_IS_JUMP     (UPD_IS_JUMP),
        .UPD_PRED_TAKEN  (UPD_PRED_TAKEN),
        .UPD_PRED_TARGET (UPD_PRED_TARGET),
        .UPD_MISPRED     (UPD_MISPRED),
        .STAT_UPD        (STAT_UPD),
        .STAT_MISPRED    (STAT_MISPRED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        rst;
        bit [31:0] predPc;
        bit        updEn;
        bit [31:0] updPc;
        bit        taken;
        bit [31:0] target;
        bit        isJump;
        bit        predTaken;
        bit [31:0] predTarget;
    } stim_t;

    typedef struct {
        int        cycle;
        bit        hit;
        bit        taken;
        bit [31:0] target;
        bit        mispred;
        longint unsigned statUpd;
        longint unsigned statMis;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   cycle  = 0;

    // ---------------- behavioural model ----------------
    bit              mValid  [ENTRIES];
    longint unsigned mTag    [ENTRIES];
    bit [31:0]       mTarget [ENTRIES];
    int              mCtr    [ENTRIES];
    longint unsigned mStatUpd, mStatMis;

    function automatic int idxOf(bit [31:0] pc);
        return int'((longint'(pc) / 4) % ENTRIES);
    endfunction

    function automatic longint unsigned tagOf(bit [31:0] pc);
        return (longint'(pc) / (4 * ENTRIES)) % (64'd1 << TAG_BITS);
    endfunction

    function automatic bit mHit(bit [31:0] pc);
        return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
    endfunction

    function automatic bit mTaken(bit [31:0] pc);
        return mHit(pc) && (mCtr[idxOf(pc)] >= 2);
    endfunction

    function automatic bit [31:0] mNext(bit [31:0] pc);
        return mTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0;
            mCtr[i]   = 1;
        end
        mStatUpd = 0;
        mStatMis = 0;
    endtask

    function automatic bit mMispred(stim_t s);
        return s.updEn && ((s.taken != s.predTaken) || (s.taken && s.target != s.predTarget));
    endfunction

    task automatic modelUpdate(stim_t s);
        int i;
        if (s.rst) begin
            modelReset();
            return;
        end
        if (!s.updEn) return;
        if (mMispred(s) && mStatMis < CNT_MAX) mStatMis++;
        if (mStatUpd < CNT_MAX) mStatUpd++;
        i = idxOf(s.updPc);
        if (mHit(s.updPc)) begin
            if (s.isJump)     mCtr[i] = 3;
            else if (s.taken) mCtr[i] = (mCtr[i] == 3) ? 3 : mCtr[i] + 1;
            else              mCtr[i] = (mCtr[i] == 0) ? 0 : mCtr[i] - 1;
            if (s.taken) mTarget[i] = s.target & 32'hFFFF_FFFC;
        end else if (s.taken) begin
            mValid[i]  = 1'b1;
            mTag[i]    = tagOf(s.updPc);
            mTarget[i] = s.target & 32'hFFFF_FFFC;
            mCtr[i]    = s.isJump ? 3 : 2;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, int cyc, longint unsigned act, longint unsigned exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            check("pred_hit",     e.cycle, 64'(PRED_HIT),     64'(e.hit));
            check("pred_taken",   e.cycle, 64'(PRED_TAKEN),   64'(e.taken));
            check("pred_target",  e.cycle, 64'(PRED_TARGET),  64'(e.target));
            check("upd_mispred",  e.cycle, 64'(UPD_MISPRED),  64'(e.mispred));
            check("stat_upd",     e.cycle, 64'(STAT_UPD),     e.statUpd);
            check("stat_mispred", e.cycle, 64'(STAT_MISPRED), e.statMis);
        end
    end

    // ---------------- stimulus ----------------
    function automatic stim_t idle(bit [31:0] pc);
        stim_t s;
        s = '{default: '0};
        s.predPc = pc;
        return s;
    endfunction

    function automatic stim_t upd(bit [31:0] predPc, bit [31:0] pc, bit taken, bit [31:0] tgt,
                                  bit isJump, bit pTaken, bit [31:0] pTarget);
        stim_t s;
        s = idle(predPc);
        s.updEn = 1'b1;
        s.updPc = pc;
        s.taken = taken;
        s.target = tgt;
        s.isJump = isJump;
        s.predTaken = pTaken;
        s.predTarget = pTarget;
        return s;
    endfunction

    task automatic step(stim_t s);
        exp_t e;
        RST = s.rst;
        PRED_PC = s.predPc;
        UPD_EN = s.updEn;
        UPD_PC = s.updPc;
        UPD_TAKEN = s.taken;
        UPD_TARGET = s.target;
        UPD_IS_JUMP = s.isJump;
        UPD_PRED_TAKEN = s.predTaken;
        UPD_PRED_TARGET = s.predTarget;
        e.cycle   = cycle;
        e.hit     = mHit(s.predPc);
        e.taken   = mTaken(s.predPc);
        e.target  = mNext(s.predPc);
        e.mispred = mMispred(s);
        e.statUpd = mStatUpd;
        e.statMis = mStatMis;
        expQ.push_back(e);
        @(posedge CLK);
        modelUpdate(s);
        cycle++;
        #1;
    endtask

    function automatic bit [31:0] randPc();
        bit [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
        if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
        return pc;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bit [31:0] pc;
        bit        t;

        // Initial reset, with no check because DUT state is unknown beforehand.
        s = idle(32'h100);
        s.rst = 1'b1;
        RST = 1'b1; PRED_PC = 0; UPD_EN = 0; UPD_PC = 0; UPD_TAKEN = 0; UPD_TARGET = 0;
        UPD_IS_JUMP = 0; UPD_PRED_TAKEN = 0; UPD_PRED_TARGET = 0;
        @(posedge CLK);
        modelUpdate(s);
        #1;

        // Post-reset lookup: a miss, with fall-through to PC+4.
        step(idle(32'h100));
        // Allocate 0x100 -> 0x80, then confirm the hit.
        step(upd(32'h0, 32'h100, 1, 32'h80, 0, 0, 32'h104));
        step(idle(32'h100));
        // Four not-taken updates: 10 -> 01 -> 00 -> 00.
        step(upd(32'h100, 32'h100, 0, 32'h0, 0, 1, 32'h80));
        for (int k = 0; k < 3; k++) step(upd(32'h100, 32'h100, 0, 32'h0, 0, 0, 32'h104));
        step(idle(32'h100));
        // A taken update must reach only 01 and stay not-taken after saturating at 00.
        step(upd(32'h100, 32'h100, 1, 32'h80, 0, 0, 32'h104));
        step(idle(32'h100));
        // Direct-mapped conflict: JAL at 0x40, then 0x440 evicts it.
        step(upd(32'h40, 32'h40, 1, 32'h200, 1, 0, 32'h44));
        step(idle(32'h40));
        step(upd(32'h440, 32'h440, 1, 32'h500, 0, 0, 32'h444));
        step(idle(32'h40));
        step(idle(32'h440));
        // Same-cycle lookup and update: pre-update view, then the new one.
        step(upd(32'h100, 32'h100, 1, 32'h300, 1, 0, 32'h104));
        step(idle(32'h100));
        // PC+4 wrap on a miss.
        step(idle(32'hFFFF_FFFC));

        // Randomised traffic, including the occasional reset.
        for (int k = 0; k < 1500; k++) begin
            pc = randPc();
            t  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                s = upd(randPc(), pc, t, $urandom, 1'($urandom_range(0, 5) == 0), 0, 0);
                if (s.isJump) s.taken = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    s.predTaken  = mTaken(pc);
                    s.predTarget = mNext(pc);
                    if ($urandom_range(0, 1) == 1) s.target = s.predTarget;
                end else begin
                    s.predTaken  = 1'($urandom_range(0, 1));
                    s.predTarget = $urandom;
                end
            end else begin
                s = idle(randPc());
            end
            if ($urandom_range(0, 60) == 0) s.rst = 1'b1;
            step(s);
        end

        // Drive both statistics counters into saturation with back-to-back mispredicts.
        for (int k = 0; k < int'(CNT_MAX) + 4; k++)
            step(upd(32'h100, 32'h100, 1, 32'h80, 0, 0, 32'h104));
        step(idle(32'h100));

        // Reset in the middle of an update stream. The reset-cycle update is dropped.
        step(upd(32'h100, 32'h180, 1, 32'h900, 0, 0, 32'h184));
        s = upd(32'h100, 32'h1C0, 1, 32'hA00, 0, 0, 32'h1C4);
        s.rst = 1'b1;
        step(s);
        step(idle(32'h1C0));
        step(upd(32'h180, 32'h140, 1, 32'hB00, 0, 1, 32'hB00));
        step(idle(32'h180));
        step(idle(32'h140));

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge CLK);
        #1;
        if (expQ.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/otter_bpred.md
OTTER_BPRED -- requirements
Module: otter_bpred

Interface
REQ-001 The block SHALL take parameter ENTRIES, default 16, meaning the number of predictor entries (power of two, 4..256).
REQ-002 The block SHALL take parameter TAG_BITS, default 8, meaning the number of PC bits stored per entry above the index.
REQ-003 The block SHALL take parameter CNT_BITS, default 16, meaning the width of each performance counter.
REQ-004 CLK  in  1  sole clock; all state updates on the posedge.
REQ-005 RST  in  1  reset; synchronous and active-high.
REQ-006 PRED_PC  in  32  fetch-stage PC being looked up.
REQ-007 PRED_HIT  out  1  valid entry with matching tag exists for PRED_PC.
REQ-008 PRED_TAKEN  out  1  predicted taken.
REQ-009 PRED_TARGET  out  32  next fetch PC.
REQ-010 UPD_EN  in  1  execute stage resolves a branch or jump this cycle.
REQ-011 UPD_PC  in  32  PC of the resolved instruction.
REQ-012 UPD_TAKEN  in  1  actual outcome.
REQ-013 UPD_TARGET  in  32  actual target when taken.
REQ-014 UPD_IS_JUMP  in  1  instruction is JAL/JALR (unconditional).
REQ-015 UPD_PRED_TAKEN / UPD_PRED_TARGET  in  1 / 32  prediction that was carried down the pipeline with the instruction.
REQ-016 UPD_MISPRED  out  1  combinational flush request for the resolving instruction.
REQ-017 STAT_UPD / STAT_MISPRED  out  CNT_BITS each  resolved-instruction count / mispredict count.

Function
REQ-018 The index SHALL be PC[log2(ENTRIES)+1:2]; the tag SHALL be the next TAG_BITS bits above the index.
REQ-019 Each entry SHALL hold a valid bit, a tag, a 30-bit word target (target[31:2]), and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-020 Lookup SHALL be combinational with zero-cycle latency; PRED_HIT = valid & tag match.
REQ-021 PRED_TAKEN SHALL equal PRED_HIT & counter[1].
REQ-022 PRED_TARGET SHALL equal the stored target when PRED_TAKEN, else PRED_PC+4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-023 UPD_MISPRED SHALL be UPD_EN & ((UPD_TAKEN != UPD_PRED_TAKEN) | (UPD_TAKEN & UPD_TARGET != UPD_PRED_TARGET)).
REQ-024 On an update hit with a conditional branch, the counter SHALL increment on taken and decrement on not-taken, saturating at 11 and 00.
REQ-025 On an update hit with a taken outcome, the target SHALL be overwritten with UPD_TARGET.
REQ-026 On an update miss with a taken outcome, the entry SHALL be allocated: valid=1, new tag and target, counter=10.
REQ-027 On an update miss with a not-taken outcome, the table SHALL NOT be written.
REQ-028 Any update with UPD_IS_JUMP=1 SHALL set the counter to 11, whether it hits or allocates.
REQ-029 An allocation SHALL overwrite a valid entry that has a different tag (direct-mapped, no replacement policy).
REQ-030 When lookup and update target the same index in the same cycle, the lookup SHALL return pre-update state, with no bypass; the new state is visible the next cycle.
REQ-031 STAT_UPD SHALL increment on every UPD_EN cycle; STAT_MISPRED SHALL increment when UPD_MISPRED=1.
REQ-032 Both statistics counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-033 Updates with UPD_EN=0 SHALL change no state.

Reset
REQ-034 When RST=1 at a posedge, all valid bits SHALL clear, all counters SHALL be set to 01, and STAT_UPD and STAT_MISPRED SHALL be set to 0, in a single cycle.
REQ-035 RST SHALL take priority over a simultaneous UPD_EN.
REQ-036 In the cycle after reset, PRED_HIT=0, PRED_TAKEN=0 and PRED_TARGET=PRED_PC+4 for any PRED_PC.
REQ-037 Tag and target storage SHALL need no reset; the cleared valid bits mask them.

Structure
REQ-038 The entry struct (valid, tag, target, ctr) and the counter encodings SHALL live in the shared package otter_pkg, next to the existing pipeline-register structs.
REQ-039 The saturating 2-bit counter update SHALL be one sub-module, sat_ctr2 (inputs ctr, taken, force_strong; output next ctr).
REQ-040 The storage SHALL be flops, not a RAM macro, so that the single-cycle clear is possible.

Verification
REQ-041 Reset, then PRED_PC=0x100 -> PRED_HIT=0, PRED_TAKEN=0, PRED_TARGET=0x104.
REQ-042 Update PC=0x100 taken, target=0x80, conditional -> next cycle PRED_PC=0x100 gives HIT=1, TAKEN=1, TARGET=0x80.
REQ-043 Apply four not-taken updates to PC=0x100 -> counter goes 10->01->00->00, PRED_TAKEN=0 from the first update onward, and the counter stays at 00 after the fourth.
REQ-044 Update PC=0x40 with a JAL to 0x200, then a taken update to PC=0x440 (same index, different tag, ENTRIES=16) -> PC=0x40 misses and PC=0x440 hits.
REQ-045 Lookup and update of PC=0x100 in the same cycle -> pre-update prediction that cycle, new prediction the next cycle; a mispredicted update raises UPD_MISPRED=1 and STAT_MISPRED increments by 1.
REQ-046 Force STAT_MISPRED to 0xFFFF, then apply a mispredicted update -> STAT_MISPRED stays 0xFFFF; assert RST during a stream of UPD_EN cycles -> all state is cleared and the update in the reset cycle is ignored.
